// File: rtl/benes_cfg_loader.sv
// rtl/benes_cfg_loader.sv - shadow-buffered Benes switch configuration loader
// Commits a complete stage set as a wavefront, one stage per cycle, behind the data pipeline.
module benes_cfg_loader #(
  parameter int SIZE       = 32,
  parameter int STAGE_NUM  = 2*$clog2(SIZE)-1,
  parameter int SWITCH_NUM = SIZE/2,
  parameter int SIDX_W     = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SIDX_W-1:0]     cfg_stage,
  input  logic [SWITCH_NUM-1:0] cfg_data,
  input  logic                  cfg_last,
  output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
  output logic                  busy,
  output logic                  cfg_err,
  output logic [3:0]            cfg_epoch
);

  typedef enum logic {LOAD, PROP} state_t;

  state_t                  state_q;
  logic [SIDX_W-1:0]       wave_q;
  logic [STAGE_NUM-1:0]    mask_q;
  logic                    err_q;
  logic [3:0]              epoch_q;
  logic [SWITCH_NUM-1:0]   shadow_q [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0]   switch_q [0:STAGE_NUM-1];

  logic                    accept;
  logic                    in_range;
  logic [STAGE_NUM-1:0]    mask_d;
  logic                    mask_full;

  always_comb begin
    accept    = cfg_valid && cfg_ready;
    in_range  = (32'(cfg_stage) < STAGE_NUM);
    mask_d    = mask_q | (STAGE_NUM'(1) << cfg_stage);
    mask_full = (mask_d == '1);
  end

  // Shadow is frozen while in PROP, so the wave reads it directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wave_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      epoch_q <= '0;
      for (int s = 0; s < STAGE_NUM; s++) begin
        shadow_q[s] <= '0;
        switch_q[s] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (!in_range) begin
              err_q <= 1'b1;
            end else begin
              shadow_q[cfg_stage] <= cfg_data;
              if (cfg_last && mask_full) begin
                state_q <= PROP;
                mask_q  <= '0;
                wave_q  <= '0;
              end else begin
                mask_q <= mask_d;
                if (cfg_last) err_q <= 1'b1;
              end
            end
          end
        end
        PROP: begin
          switch_q[wave_q] <= shadow_q[wave_q];
          if (wave_q == SIDX_W'(STAGE_NUM-1)) begin
            state_q <= LOAD;
            epoch_q <= epoch_q + 4'd1;
          end else begin
            wave_q <= wave_q + 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign switch_set = switch_q;
  assign busy       = (state_q == PROP);
  assign cfg_ready  = (state_q == LOAD) && !rst;
  assign cfg_err    = err_q;
  assign cfg_epoch  = epoch_q;

endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb/tb_benes_cfg_loader.sv - scoreboard bench for benes_cfg_loader
module tb_benes_cfg_loader;
  localparam int SIZE = 32, STAGE_NUM = 9, SWITCH_NUM = 16, SIDX_W = 4;
  localparam int K_SW = 0, K_ERR = 1, K_BUSY = 2, K_EPOCH = 3;

  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_last = 1'b0;
  logic [SIDX_W-1:0] cfg_stage = '0;
  logic [SWITCH_NUM-1:0] cfg_data = '0;
  logic cfg_ready, busy, cfg_err;
  logic [3:0] cfg_epoch;
  logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1];

  benes_cfg_loader #(.SIZE(SIZE), .STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM), .SIDX_W(SIDX_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stage(cfg_stage),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .switch_set(switch_set), .busy(busy),
    .cfg_err(cfg_err), .cfg_epoch(cfg_epoch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int kind; int idx; logic [31:0] val; } exp_t;
  exp_t exp_q [$];
  exp_t mon_e;
  int nvec = 0, nerr = 0;

  logic [15:0] shadow_m [STAGE_NUM];
  logic [15:0] sw_m [STAGE_NUM];
  logic [15:0] set_d [STAGE_NUM];
  logic [STAGE_NUM-1:0] mask_m;
  logic [3:0] epoch_m;
  int busy_until = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // A later expectation for the same cycle/output replaces an earlier one.
  function automatic void push_exp(input int c, input int k, input int i, input logic [31:0] v);
    for (int j = exp_q.size()-1; j >= 0; j--)
      if (exp_q[j].cyc == c && exp_q[j].kind == k && exp_q[j].idx == i) exp_q.delete(j);
    exp_q.push_back('{cyc: c, kind: k, idx: i, val: v});
  endfunction

  always @(negedge clk) begin
    for (int j = exp_q.size()-1; j >= 0; j--) begin
      if (exp_q[j].cyc == cyc) begin
        mon_e = exp_q[j];
        exp_q.delete(j);
        case (mon_e.kind)
          K_SW:    chk($sformatf("switch_set[%0d]@%0d", mon_e.idx, cyc), {16'b0, switch_set[mon_e.idx]}, mon_e.val);
          K_ERR:   chk($sformatf("cfg_err@%0d", cyc), {31'b0, cfg_err}, mon_e.val);
          K_BUSY:  chk($sformatf("busy@%0d", cyc), {31'b0, busy}, mon_e.val);
          default: chk($sformatf("cfg_epoch@%0d", cyc), {28'b0, cfg_epoch}, mon_e.val);
        endcase
      end
    end
  end

  task automatic put(input int stage, input logic [15:0] data, input bit last);
    int t;
    bit acc;
    logic [3:0] ep_old;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_stage = stage[3:0];
    cfg_data  = data;
    cfg_last  = last;
    t   = cyc + 1;
    acc = (t > busy_until);
    #1 chk($sformatf("cfg_ready@%0d", cyc), {31'b0, cfg_ready}, {31'b0, acc});
    if (acc) begin
      if (stage >= STAGE_NUM) begin
        push_exp(t, K_ERR, 0, 1);
        push_exp(t+1, K_ERR, 0, 0);
      end else begin
        shadow_m[stage] = data;
        mask_m[stage] = 1'b1;
        push_exp(t, K_ERR, 0, 0);
        if (last && mask_m == '1) begin
          mask_m = '0;
          busy_until = t + STAGE_NUM;
          ep_old = epoch_m;
          epoch_m++;
          push_exp(t, K_BUSY, 0, 1);
          push_exp(t+STAGE_NUM-1, K_BUSY, 0, 1);
          push_exp(t+STAGE_NUM-1, K_EPOCH, 0, ep_old);
          push_exp(t+STAGE_NUM, K_BUSY, 0, 0);
          push_exp(t+STAGE_NUM, K_EPOCH, 0, epoch_m);
          for (int s = 0; s < STAGE_NUM; s++) begin
            push_exp(t+1+s, K_SW, s, shadow_m[s]);
            if (s+1 < STAGE_NUM) push_exp(t+1+s, K_SW, s+1, sw_m[s+1]);
            sw_m[s] = shadow_m[s];
          end
        end else if (last) begin
          push_exp(t, K_ERR, 0, 1);
          push_exp(t+1, K_ERR, 0, 0);
          push_exp(t+1, K_BUSY, 0, 0);
          for (int s = 0; s < STAGE_NUM; s++) push_exp(t+1, K_SW, s, sw_m[s]);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    int r;
    @(negedge clk);
    rst = 1'b1;
    cfg_valid = 1'b0;
    r = cyc + 1;
    #1 chk("cfg_ready_in_rst", {31'b0, cfg_ready}, 0);
    for (int j = exp_q.size()-1; j >= 0; j--)
      if (exp_q[j].cyc >= r) exp_q.delete(j);
    for (int s = 0; s < STAGE_NUM; s++) begin
      shadow_m[s] = '0;
      sw_m[s] = '0;
      push_exp(r, K_SW, s, 0);
    end
    mask_m = '0;
    epoch_m = '0;
    busy_until = -1;
    push_exp(r, K_ERR, 0, 0);
    push_exp(r, K_BUSY, 0, 0);
    push_exp(r, K_EPOCH, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("cfg_ready_after_rst", {31'b0, cfg_ready}, 1);
  endtask

  task automatic load_set(input bit hold_valid);
    for (int s = 0; s < STAGE_NUM; s++) put(s, set_d[s], s == STAGE_NUM-1);
    if (hold_valid) repeat (STAGE_NUM) put(0, 16'hFFFF, 1'b1);
    else idle(STAGE_NUM + 1);
  endtask

  task automatic rand_set();
    for (int s = 0; s < STAGE_NUM; s++) set_d[s] = 16'($urandom);
  endtask

  initial begin
    do_reset();

    set_d = '{16'h00FF, 16'h0FF0, 16'h3CC3, 16'h6996, 16'h6996, 16'h5555, 16'h5555, 16'h5555, 16'h5555};
    load_set(1'b0);

    for (int s = 0; s < 8; s++) put(s, 16'h1000 + 16'(s), s == 7);
    idle(3);

    put(9, 16'hDEAD, 1'b0);
    put(15, 16'hBEEF, 1'b1);
    rand_set();
    load_set(1'b0);

    for (int s = 0; s < STAGE_NUM; s++) begin
      if (s == 3) put(3, 16'hAAAA, 1'b0);
      put(s, (s == 3) ? 16'h1234 : 16'h0F00 + 16'(s), s == STAGE_NUM-1);
    end
    idle(STAGE_NUM + 1);
    chk("stage3_last_write", {16'b0, switch_set[3]}, 32'h1234);

    rand_set();
    for (int s = 0; s < STAGE_NUM; s++) put(s, set_d[s], s == STAGE_NUM-1);
    idle(4);
    do_reset();
    idle(2);

    for (int n = 0; n < 16; n++) begin
      rand_set();
      load_set(1'b1);
    end
    idle(2);
    chk("epoch_wrapped", {28'b0, cfg_epoch}, 0);

    idle(12);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/benes_cfg_loader.md
BENES_CFG_LOADER -- requirements
Module: benes_cfg_loader

Interface
REQ-001 The block SHALL have these parameters:
- SIZE, default 32: network port count.
- STAGE_NUM, default 2*log2(SIZE)-1 = 9: switch stages.
- SWITCH_NUM, default SIZE/2 = 16: switches per stage.
- SIDX_W, default 4: stage-index width, ceil(log2(STAGE_NUM)).

REQ-002 The block SHALL have these ports:
- clk  in  1  the one clock; all logic rises on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- cfg_valid  in  1  a configuration word is offered.
- cfg_ready  out  1  the block accepts a word this cycle.
- cfg_stage  in  SIDX_W  target stage index of the word.
- cfg_data  in  SWITCH_NUM  switch bits for that stage; bit k drives switch k.
- cfg_last  in  1  final word of the set; requests a commit.
- switch_set  out  SWITCH_NUM x STAGE_NUM  unpacked array [0:STAGE_NUM-1], driven straight into the network's switch_set input.
- busy  out  1  a commit wavefront is propagating.
- cfg_err  out  1  one-cycle error pulse.
- cfg_epoch  out  4  count of completed commits.

Function
REQ-003 A word SHALL be accepted only on a cycle where cfg_valid=1 and cfg_ready=1.
REQ-004 An accepted word with cfg_stage < STAGE_NUM SHALL write cfg_data into shadow[cfg_stage] and set written_mask[cfg_stage].
REQ-005 A repeated write to the same stage before commit SHALL overwrite that shadow entry. The last write wins.
REQ-006 An accepted word with cfg_stage >= STAGE_NUM SHALL be dropped and SHALL pulse cfg_err for one cycle. Shadow and mask SHALL stay unchanged.
REQ-007 The FSM SHALL have two states: LOAD (cfg_ready=1, busy=0) and PROP (cfg_ready=0, busy=1).
REQ-008 In LOAD, an accepted in-range word with cfg_last=1 SHALL commit if the mask, including this word's bit, is all ones.
- On commit: go to PROP, clear written_mask, reset the wave counter to 0.
REQ-009 An accepted cfg_last=1 word that leaves the mask incomplete SHALL still write its data and set its mask bit.
- It SHALL pulse cfg_err, perform no commit, and keep the state in LOAD.
REQ-010 A cfg_last=1 word with an out-of-range stage SHALL follow REQ-006 and SHALL NOT commit.
REQ-011 Commit wavefront: if the commit word is accepted at edge T, switch_set[s] SHALL take shadow[s] at edge T+1+s, for s = 0 .. STAGE_NUM-1.
- This matches the one-register-per-stage pipeline, so one data vector sees one coherent configuration.
REQ-012 Stages not yet reached by the wave SHALL keep their previous value.
REQ-013 After switch_set[STAGE_NUM-1] updates at edge T+STAGE_NUM, the FSM SHALL return to LOAD and increment cfg_epoch by 1, wrapping 15 -> 0.
- cfg_ready is therefore 0 for exactly STAGE_NUM cycles after the commit edge.
REQ-014 Shadow SHALL NOT be written during PROP. Since cfg_ready=0, no word is accepted.
REQ-015 The shadow values latched at commit SHALL be the ones propagated. A separate wave copy is not required, because shadow is frozen in PROP.
REQ-016 cfg_err, busy, cfg_ready and switch_set SHALL be registered outputs or decodes of registered state only. There SHALL be no combinational path from cfg_* inputs to any output.
REQ-017 Shadow entries SHALL persist across commits. A later set needs all STAGE_NUM stages written again before its commit succeeds.

Reset
REQ-018 While rst=1 at a rising edge, the block SHALL set:
- every switch_set[s] = 0 (all switches in pass state)
- all shadow entries = 0, written_mask = 0
- state = LOAD, cfg_epoch = 0, cfg_err = 0, busy = 0.
REQ-019 cfg_ready SHALL be 0 in any cycle where rst=1, and 1 on the first cycle after rst deasserts.
REQ-020 rst asserted during PROP SHALL abort the wave. The next edge yields the full REQ-018 state, and partially updated stages are zeroed.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load stages 0..8 with 16'h00FF, 16'h0FF0, 16'h3CC3, 16'h6996, 16'h6996, 16'h5555 x4; last word flagged -> switch_set[s] updates one stage per cycle over 9 cycles; busy=1 for 9 cycles; cfg_epoch 0->1.
- Write stages 0..7 only, with cfg_last on stage 7 -> cfg_err pulses 1 cycle; switch_set unchanged; state LOAD.
- Send cfg_stage=9 or 15 -> cfg_err pulse, word dropped; then a complete set commits normally.
- Write stage 3 twice (16'hAAAA, then 16'h1234) before commit -> switch_set[3]=16'h1234 at edge T+4.
- Assert rst at wave cycle 4 -> all switch_set=0, cfg_epoch=0, cfg_ready=1 the cycle after release.
- Complete 16 commits -> cfg_epoch wraps to 0; cfg_valid held high during PROP is never accepted.
